// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA grid renderer.
// Holds palette, game/snake encodings, default 640x480 timing and the stage-1 bundle.
package vga_pkg;

    // Palette, 12-bit RGB 4:4:4
    localparam logic [11:0] COL_BG    = 12'h8A4;
    localparam logic [11:0] COL_WALL  = 12'hAAA;
    localparam logic [11:0] COL_BODY  = 12'h0C0;
    localparam logic [11:0] COL_HEAD  = 12'hFF0;
    localparam logic [11:0] COL_MINE  = 12'hF00;
    localparam logic [11:0] COL_START = 12'h00F;
    localparam logic [11:0] COL_OVER  = 12'h800;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2,
        ST_PAUSE = 2'd3
    } game_status_e;

    typedef enum logic [1:0] {
        SN_NONE = 2'd0,
        SN_HEAD = 2'd1,
        SN_BODY = 2'd2,
        SN_WALL = 2'd3
    } snake_code_e;

    // Default 640x480 @ 60 Hz timing
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    // Per-pixel facts captured in stage 1
    typedef struct packed {
        logic        valid;
        logic        vis;
        logic        hs;
        logic        vs;
        snake_code_e snake;
        logic        apple;
        logic        mine;
    } pix_s1_t;

    // Halve each 4-bit channel; the mask drops bits that
    // slid in from the neighbouring channel.
    function automatic logic [11:0] dim_color(input logic [11:0] c);
        return (c >> 1) & 12'h777;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, pixel/line counters, raw syncs and frame_start pulse.
// Ports: clk, rst (sync, active-high) in; pix_en, x_pos, y_pos, hsync_raw, vsync_raw, visible, frame_start out.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       visible,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);

    logic [DIV_W-1:0] div_cnt;
    logic             x_last;
    logic             y_last;

    // With CLK_DIV=1 DIV_LAST is 0, so pix_en stays high.
    assign pix_en = (div_cnt == DIV_LAST);
    assign x_last = (x_pos == H_LAST);
    assign y_last = (y_pos == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_pos       <= '0;
            y_pos       <= '0;
            frame_start <= 1'b0;
        end else begin
            // Registered together with the wrap, so it is high in the
            // clk where both counters first read 0.
            frame_start <= pix_en && x_last && y_last;
            if (pix_en) begin
                if (x_last) begin
                    x_pos <= '0;
                    y_pos <= y_last ? 10'd0 : y_pos + 10'd1;
                end else begin
                    x_pos <= x_pos + 10'd1;
                end
            end
        end
    end

    assign hsync_raw = !((x_pos >= HS_START) && (x_pos < HS_END));
    assign vsync_raw = !((y_pos >= VS_START) && (y_pos < VS_END));
    assign visible   = (x_pos < H_VIS) && (y_pos < V_VIS);

endmodule

// File: rtl/vga_grid_renderer.sv
// VGA back end for the snake game: timing, grid layer compositing, 12-bit RGB out.
// Ports: clk, rst (sync, active-high), snake, apple_x/y, VGA_reward, game_status,
//        mine_x/y, mine_active in; x_pos, y_pos, hsync, vsync, color_out, frame_start out.
// Optional mine blinking is built when the macro VGA_MINE_BLINK_EN is defined.
module vga_grid_renderer
    import vga_pkg::*;
#(
    parameter int H_VISIBLE    = DEF_H_VISIBLE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_VISIBLE    = DEF_V_VISIBLE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter int CLK_DIV      = 4,
    parameter int CELL_SHIFT   = 4,
    parameter int N_MINES      = 4,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             snake,
    input  logic [5:0]             apple_x,
    input  logic [4:0]             apple_y,
    input  logic [11:0]            VGA_reward,
    input  logic [1:0]             game_status,
    input  logic [6*N_MINES-1:0]   mine_x,
    input  logic [6*N_MINES-1:0]   mine_y,
    input  logic [N_MINES-1:0]     mine_active,
    output logic [9:0]             x_pos,
    output logic [9:0]             y_pos,
    output logic                   hsync,
    output logic                   vsync,
    output logic [11:0]            color_out,
    output logic                   frame_start
);

    if (N_MINES < 1 || N_MINES > 16 || CLK_DIV < 1 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("vga_grid_renderer: parameter out of range");
    end

    localparam logic [9:0] GRID_W = 10'(H_VISIBLE >> CELL_SHIFT);
    localparam logic [9:0] GRID_H = 10'(V_VISIBLE >> CELL_SHIFT);

    localparam pix_s1_t S1_RST = '{
        valid: 1'b0,
        vis:   1'b0,
        hs:    1'b1,
        vs:    1'b1,
        snake: SN_NONE,
        apple: 1'b0,
        mine:  1'b0
    };

    logic       pix_en;
    logic       hsync_raw;
    logic       vsync_raw;
    logic       visible;
    logic [9:0] cell_x;
    logic [9:0] cell_y;
    logic       apple_hit;
    logic       mine_hit;
    logic       mine_vis;
    logic [11:0] layer;
    logic [11:0] pix_color;
    pix_s1_t    s1;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .CLK_DIV   (CLK_DIV)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .visible     (visible),
        .frame_start (frame_start)
    );

    // Stage 0: cell lookup for the pixel currently addressed.
    assign cell_x = x_pos >> CELL_SHIFT;
    assign cell_y = y_pos >> CELL_SHIFT;

    assign apple_hit = (cell_x == {4'b0, apple_x}) &&
                       (cell_y == {5'b0, apple_y});

    // Off-grid mine coordinates are rejected explicitly so that they
    // can never alias onto blanking cells.
    always_comb begin
        mine_hit = 1'b0;
        for (int i = 0; i < N_MINES; i++) begin
            if (mine_active[i] &&
                ({4'b0, mine_x[6*i +: 6]} == cell_x) &&
                ({4'b0, mine_y[6*i +: 6]} == cell_y) &&
                ({4'b0, mine_x[6*i +: 6]} < GRID_W) &&
                ({4'b0, mine_y[6*i +: 6]} < GRID_H)) begin
                mine_hit = 1'b1;
            end
        end
    end

    // Stage 1
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= S1_RST;
        end else if (pix_en) begin
            s1.valid <= 1'b1;
            s1.vis   <= visible;
            s1.hs    <= hsync_raw;
            s1.vs    <= vsync_raw;
            s1.snake <= snake_code_e'(snake);
            s1.apple <= apple_hit;
            s1.mine  <= mine_hit;
        end
    end

`ifdef VGA_MINE_BLINK_EN
    localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

    logic [BC_W-1:0] blink_cnt;
    logic            blink_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt == BC_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Masked at stage 2: the first pixel of a frame reaches this point
    // only after the frame_start update, even with CLK_DIV=1.
    assign mine_vis = s1.mine & blink_on;
`else
    assign mine_vis = s1.mine;
`endif

    // Stage 2 compositing
    always_comb begin
        layer = COL_BG;
        if (s1.snake == SN_HEAD) begin
            layer = COL_HEAD;
        end else if (mine_vis) begin
            layer = COL_MINE;
        end else if (s1.apple) begin
            layer = VGA_reward;
        end else if (s1.snake == SN_BODY) begin
            layer = COL_BODY;
        end else if (s1.snake == SN_WALL) begin
            layer = COL_WALL;
        end

        pix_color = layer;
        unique case (game_status)
            ST_START: pix_color = COL_START;
            ST_PLAY:  pix_color = layer;
            ST_OVER:  pix_color = (s1.snake == SN_HEAD) ? COL_HEAD : COL_OVER;
            ST_PAUSE: pix_color = dim_color(layer);
        endcase

        if (!s1.vis) begin
            pix_color = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_out <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else if (pix_en) begin
            color_out <= s1.valid ? pix_color : 12'h000;
            hsync     <= s1.valid ? s1.hs : 1'b1;
            vsync     <= s1.valid ? s1.vs : 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Self-checking bench for vga_grid_renderer on a reduced video mode.
// Vector table plus a cycle-level reference stream model under random stimulus.
module tb_vga_grid_renderer;
    import vga_pkg::*;

    localparam int HV = 32, HF = 4, HS = 4, HB = 4;
    localparam int VV = 16, VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int F  = HT * VT;
    localparam int CD = 2;
    localparam int CS = 2;
    localparam int NM = 8;
    localparam int BF = 2;
    localparam int WAIT_MAX = 2 * F * CD + 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    snake;
    logic [5:0]    apple_x;
    logic [4:0]    apple_y;
    logic [11:0]   VGA_reward;
    logic [1:0]    game_status;
    logic [6*NM-1:0] mine_x;
    logic [6*NM-1:0] mine_y;
    logic [NM-1:0] mine_active;
    logic [9:0]    x_pos;
    logic [9:0]    y_pos;
    logic          hsync;
    logic          vsync;
    logic [11:0]   color_out;
    logic          frame_start;

    logic [1:0] snake_map [0:15][0:7];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign snake = snake_map[4'(x_pos >> CS)][3'(y_pos >> CS)];

    vga_grid_renderer #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CD), .CELL_SHIFT(CS), .N_MINES(NM), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .snake(snake),
        .apple_x(apple_x), .apple_y(apple_y), .VGA_reward(VGA_reward),
        .game_status(game_status), .mine_x(mine_x), .mine_y(mine_y),
        .mine_active(mine_active), .x_pos(x_pos), .y_pos(y_pos),
        .hsync(hsync), .vsync(vsync), .color_out(color_out),
        .frame_start(frame_start)
    );

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       vis;
        bit       hs;
        bit       vs;
        int       sn;
        bit       ap;
        bit       mn;
        bit       bl;
    } facts_t;

    facts_t      fq[$];
    facts_t      m_f;
    int unsigned t;
    int unsigned m_n;
    int          m_x, m_y;
    logic [11:0] m_col;
    bit          m_hs, m_vs, m_fs;
    bit          armed = 0;

    function automatic bit mine_at(int cx, int cy);
        for (int i = 0; i < NM; i++)
            if (mine_active[i] && int'(mine_x[6*i +: 6]) == cx &&
                int'(mine_y[6*i +: 6]) == cy)
                return 1;
        return 0;
    endfunction

    // Facts for pixel number n (counted from reset) using inputs present now.
    function automatic facts_t sample(int unsigned n);
        facts_t f;
        int px, py, cx, cy;
        px = int'(n % HT);
        py = int'((n / HT) % VT);
        cx = px >> CS;
        cy = py >> CS;
        f.vis = (px < HV) && (py < VV);
        f.hs = !(px >= HV + HF && px < HV + HF + HS);
        f.vs = !(py >= VV + VF && py < VV + VF + VS);
        f.sn = int'(snake_map[cx][cy]);
        f.ap = (int'(apple_x) == cx) && (int'(apple_y) == cy);
        f.mn = f.vis && mine_at(cx, cy);
`ifdef VGA_MINE_BLINK_EN
        f.bl = (((n / F) / BF) % 2) == 0;
`else
        f.bl = 1;
`endif
        return f;
    endfunction

    function automatic logic [11:0] expect_col(facts_t f, logic [1:0] st,
                                               logic [11:0] rw);
        logic [11:0] c;
        if (!f.vis) return 12'h000;
        if (st == 2'd0) return COL_START;
        if (st == 2'd2) return (f.sn == 1) ? COL_HEAD : COL_OVER;
        if (f.sn == 1) c = COL_HEAD;
        else if (f.mn && f.bl) c = COL_MINE;
        else if (f.ap) c = rw;
        else if (f.sn == 2) c = COL_BODY;
        else if (f.sn == 3) c = COL_WALL;
        else c = COL_BG;
        if (st == 2'd3)
            c = {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
        return c;
    endfunction

    // Each pixel tick: sample facts for the addressed pixel; the output
    // shows the pixel sampled one tick earlier, rendered with the current
    // status and reward colour.
    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            fq.delete();
            m_col = 12'h000;
            m_hs = 1;
            m_vs = 1;
            m_fs = 0;
            m_x = 0;
            m_y = 0;
            armed = 1;
        end else begin
            m_fs = 0;
            if (t % CD == CD - 1) begin
                m_n = t / CD;
                fq.push_back(sample(m_n));
                if (fq.size() > 1) begin
                    m_f = fq.pop_front();
                    m_col = expect_col(m_f, game_status, VGA_reward);
                    m_hs = m_f.hs;
                    m_vs = m_f.vs;
                end
                m_fs = ((m_n + 1) % F) == 0;
                m_x = int'((m_n + 1) % HT);
                m_y = int'(((m_n + 1) / HT) % VT);
            end
            t++;
        end
    end

    always @(negedge clk) begin
        if (armed)
            check("stream", {x_pos, y_pos, hsync, vsync, color_out, frame_start},
                  {10'(m_x), 10'(m_y), m_hs, m_vs, m_col, m_fs});
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0]  st;
        logic [1:0]  sn;
        int          mch;
        int          mx;
        int          my;
        bit          mon;
        int          ax;
        int          ay;
        logic [11:0] rw;
        int          cx;
        int          cy;
        logic [11:0] exp;
    } vec_t;

    vec_t vec [18];
    vec_t v;
    int   n;
    bit   ok;

    task automatic clear_inputs();
        for (int cx = 0; cx < 16; cx++)
            for (int cy = 0; cy < 8; cy++)
                snake_map[cx][cy] = 2'd0;
        mine_x = '1;
        mine_y = '1;
        mine_active = '0;
        apple_x = 6'd63;
        apple_y = 5'd31;
        VGA_reward = 12'h000;
        game_status = 2'd1;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1;
        repeat (cycles) @(negedge clk);
        rst = 0;
    endtask

    task automatic wait_xy(input int px, input int py, output bit found);
        found = 0;
        for (int i = 0; i < WAIT_MAX && !found; i++) begin
            @(negedge clk);
            if (int'(x_pos) == px && (py < 0 || int'(y_pos) == py))
                found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_xy: position (%0d,%0d) never reached", px, py);
        end
    endtask

    task automatic randomize_inputs();
        case ($urandom_range(0, 4))
            0: game_status = 2'($urandom_range(0, 3));
            1: begin
                for (int i = 0; i < NM; i++) begin
                    mine_x[6*i +: 6] = 6'($urandom_range(0, 9));
                    mine_y[6*i +: 6] = 6'($urandom_range(0, 5));
                end
                mine_active = NM'($urandom);
            end
            2: begin
                apple_x = 6'($urandom_range(0, 9));
                apple_y = 5'($urandom_range(0, 5));
                VGA_reward = 12'($urandom);
            end
            default: begin
                for (int cx = 0; cx < 16; cx++)
                    for (int cy = 0; cy < 8; cy++)
                        snake_map[cx][cy] = ($urandom_range(0, 2) == 0) ?
                                            2'($urandom_range(1, 3)) : 2'd0;
            end
        endcase
    endtask

    initial begin
        vec[0]  = '{2'd1, 2'd1, 0, 5, 3, 1, 63, 31, 12'h000, 5, 3, COL_HEAD};
        vec[1]  = '{2'd1, 2'd0, 0, 5, 3, 1, 63, 31, 12'h000, 5, 3, COL_MINE};
        vec[2]  = '{2'd1, 2'd0, 0, 5, 3, 0, 5, 3, 12'h0F0, 5, 3, 12'h0F0};
        vec[3]  = '{2'd1, 2'd2, 0, 0, 0, 0, 63, 31, 12'h000, 4, 2, COL_BODY};
        vec[4]  = '{2'd1, 2'd3, 0, 0, 0, 0, 63, 31, 12'h000, 0, 0, COL_WALL};
        vec[5]  = '{2'd1, 2'd0, 0, 0, 0, 0, 63, 31, 12'h000, 3, 1, COL_BG};
        vec[6]  = '{2'd3, 2'd0, 0, 0, 0, 0, 63, 31, 12'h000, 3, 1, 12'h452};
        vec[7]  = '{2'd2, 2'd2, 0, 0, 0, 0, 63, 31, 12'h000, 2, 2, COL_OVER};
        vec[8]  = '{2'd2, 2'd1, 0, 0, 0, 0, 63, 31, 12'h000, 2, 2, COL_HEAD};
        vec[9]  = '{2'd0, 2'd1, 0, 0, 0, 0, 63, 31, 12'h000, 1, 1, COL_START};
        vec[10] = '{2'd1, 2'd0, 7, 7, 3, 1, 63, 31, 12'h000, 7, 3, COL_MINE};
        vec[11] = '{2'd1, 2'd0, 7, 7, 3, 1, 63, 31, 12'h000, 6, 3, COL_BG};
        vec[12] = '{2'd1, 2'd0, 7, 7, 2, 1, 63, 31, 12'h000, 7, 3, COL_BG};
        vec[13] = '{2'd1, 2'd0, 3, 8, 3, 1, 63, 31, 12'h000, 7, 3, COL_BG};
        vec[14] = '{2'd3, 2'd0, 0, 0, 0, 0, 2, 1, 12'hFFF, 2, 1, 12'h777};
        vec[15] = '{2'd3, 2'd0, 0, 2, 1, 1, 2, 1, 12'h0F0, 2, 1, 12'h700};
        vec[16] = '{2'd0, 2'd0, 0, 0, 0, 0, 63, 31, 12'h000, 9, 1, 12'h000};
        vec[17] = '{2'd1, 2'd3, 0, 0, 0, 0, 63, 31, 12'h000, 1, 4, 12'h000};

        rst = 1;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("reset_x", x_pos, 0);
        check("reset_sync", {hsync, vsync}, 2'b11);
        rst = 0;

        // Reset held mid-line
        repeat (57) @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        check("midrst_xy", {x_pos, y_pos}, 20'd0);
        check("midrst_sync", {hsync, vsync}, 2'b11);
        check("midrst_color", color_out, 12'h000);
        rst = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (x_pos != 10'd1 && n < 20);
        check("first_pix_en", n, CD);

        // Sync timing
        wait_xy(HV + HF, -1, ok);
        n = 0;
        while (hsync !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hsync_delay", n, 2 * CD);
        n = 0;
        while (hsync === 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("hsync_width", n, HS * CD);
        n = 0;
        while (vsync !== 1'b0 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (vsync === 1'b0 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check("vsync_width", n, VS * HT * CD);
        n = 0;
        while (frame_start !== 1'b1 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < WAIT_MAX);
        check("frame_period", n, F * CD);

        // Table vectors, each from a fresh frame
        for (int k = 0; k < 18; k++) begin
            v = vec[k];
            do_reset(2);
            clear_inputs();
            game_status = v.st;
            snake_map[v.cx][v.cy] = v.sn;
            if (v.mon) begin
                mine_x[6*v.mch +: 6] = 6'(v.mx);
                mine_y[6*v.mch +: 6] = 6'(v.my);
                mine_active[v.mch] = 1'b1;
            end
            apple_x = 6'(v.ax);
            apple_y = 5'(v.ay);
            VGA_reward = v.rw;
            wait_xy((v.cx << CS) + 1 + 2, (v.cy << CS) + 1, ok);
            if (ok) check($sformatf("vec%0d", k), color_out, v.exp);
        end

`ifdef VGA_MINE_BLINK_EN
        do_reset(2);
        clear_inputs();
        mine_x[5:0] = 6'd2;
        mine_y[5:0] = 6'd1;
        mine_active[0] = 1'b1;
        for (int fr = 0; fr < 5; fr++) begin
            wait_xy((2 << CS) + 1 + 2, (1 << CS) + 1, ok);
            if (ok) check($sformatf("blink_f%0d", fr), color_out,
                          ((fr / BF) % 2 == 0) ? COL_MINE : COL_BG);
        end
`endif

        // Randomized run against the stream model
        do_reset(3);
        clear_inputs();
        for (int i = 0; i < 8 * F * CD; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) randomize_inputs();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_grid_renderer.md
# vga_grid_renderer

Parametrised VGA back end for the snake game that replaces the fixed clock-unit-plus-display pair. It derives a pixel enable from the system clock, generates VGA timing for any mode set by parameters, and composites the grid layers (snake, apple, N mines, game-status overlays) into a 12-bit RGB stream. It sits between the game logic and the board VGA pins. Its `x_pos`/`y_pos` outputs drive the external snake-body lookup.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_VISIBLE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `CLK_DIV`, 4, system clocks per pixel; minimum 1
- `CELL_SHIFT`, 4, log2 of the grid cell size in pixels
- `N_MINES`, 4, mine channels; range 1–16
- `BLINK_FRAMES`, 16, frames per mine blink half-period (only with `VGA_MINE_BLINK_EN`)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `snake`  in  2  snake layer code for the pixel at the current `x_pos`/`y_pos`: 0 none, 1 head, 2 body, 3 wall
- `apple_x`  in  6  apple cell column
- `apple_y`  in  5  apple cell row
- `VGA_reward`  in  12  apple colour
- `game_status`  in  2  0 start, 1 play, 2 over, 3 pause
- `mine_x`  in  6*N_MINES  packed mine cell columns; channel i is bits [6i+5:6i]
- `mine_y`  in  6*N_MINES  packed mine cell rows
- `mine_active`  in  N_MINES  per-mine enable
- `x_pos`  out  10  current pixel column counter
- `y_pos`  out  10  current line counter
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `color_out`  out  12  RGB 4:4:4
- `frame_start`  out  1  one-`clk` pulse when the counters wrap to (0,0)

## Operation
- **Divider.** Counts 0..CLK_DIV-1. `pix_en` is asserted when the count equals CLK_DIV-1. With CLK_DIV=1, `pix_en` is constantly high.
- **Counters.**
  - On each `pix_en`, `x_pos` increments. At H_TOTAL-1 (H_VISIBLE+H_FP+H_SYNC+H_BP) it wraps to 0 and `y_pos` increments.
  - `y_pos` wraps to 0 at V_TOTAL-1.
  - `frame_start` pulses on the `clk` in which both counters become 0.
- **Raw sync (stage 0).**
  - Raw hsync is low while H_VISIBLE+H_FP ≤ x < H_VISIBLE+H_FP+H_SYNC.
  - Raw vsync is defined the same way on `y_pos`.
- **Stage 1 (on `pix_en`).** Registers:
  - the visible flag;
  - cell column and row (`x_pos>>CELL_SHIFT`, `y_pos>>CELL_SHIFT`);
  - the `snake` code;
  - the apple hit;
  - the OR of the mine hits: mine i hits when `mine_active[i]` is set and both cell coordinates match.
- **Stage 2 (on `pix_en`).** Registers `color_out` and the delayed syncs.
  - Not visible: 0.
  - Status 0: `COL_START`.
  - Status 2: `COL_OVER`, except a head pixel, which shows `COL_HEAD`.
  - Status 1 and 3, in priority order: head `COL_HEAD`, mine `COL_MINE`, apple `VGA_reward`, body `COL_BODY`, wall `COL_WALL`, otherwise `COL_BG`.
  - Status 3 additionally halves each channel (right shift by 1 per 4-bit channel).
- **Edge cases.**
  - Mine coordinates outside the grid never match.
  - Duplicate or overlapping mines render identically to a single mine.
  - `mine_x`, `mine_y`, `mine_active`, `game_status` and the apple inputs are sampled every pixel. Changes take effect at the next pixel; there is no frame latching.

## Timing
- `color_out`, `hsync` and `vsync` lag `x_pos`/`y_pos` by exactly 2 pixel ticks, so colour and sync stay mutually aligned.
- `snake` must be valid by the first `pix_en` after `x_pos` changes.
- All outputs change only on `clk` edges where `pix_en` is high, except `frame_start`.
- Reset values: divider 0, `x_pos` 0, `y_pos` 0, `hsync` 1, `vsync` 1, `color_out` 0, `frame_start` 0, pipeline valid bits cleared, blink counter 0 (mines visible).
- Reset asserted mid-frame restarts the frame at (0,0) on the next clock, with no partial-line output.
- Frame period is H_TOTAL*V_TOTAL*CLK_DIV clocks; 1,680,000 at the defaults.

## Configuration
- `VGA_MINE_BLINK_EN` defined:
  - A frame counter counts `frame_start` pulses modulo BLINK_FRAMES and toggles a visibility bit at each wrap.
  - While the bit is 0, mine hits are masked, so the lower-priority layers show through.
- `VGA_MINE_BLINK_EN` undefined: mines are always visible, and there is no blink counter or blink register.

## Structure
- Package `vga_pkg` holds:
  - colour constants `COL_BG`, `COL_WALL`, `COL_BODY`, `COL_HEAD`, `COL_MINE`, `COL_START`, `COL_OVER`;
  - `game_status` encodings;
  - `snake` code encodings;
  - default 640x480 timing constants.
- Sub-module `vga_timing_gen` contains the divider, counters, raw sync and `frame_start`. It takes the timing and CLK_DIV parameters.
- Compositing and the pipeline stay in the top level.

## Test plan
- **Reset values:** hold `rst` 3 clocks mid-line → `x_pos`=0, `y_pos`=0, `hsync`=1, `vsync`=1, `color_out`=0; the first `pix_en` follows 4 clocks after release.
- **Hsync timing:** defaults → `hsync` low for 384 clocks, starting 2 pixel ticks after `x_pos`=656; `vsync` low for 2 lines; `frame_start` period 1,680,000 clocks.
- **Priority:** status 1, mine 0 at (5,3) active, `snake`=1 at that cell → `COL_HEAD`. Then `snake`=0 → `COL_MINE`. Then `mine_active`=0 with apple at (5,3), `VGA_reward`=12'h0F0 → 12'h0F0.
- **Last mine channel:** N_MINES=8, only mine 7 active at (39,29) → `COL_MINE` at pixels x=624..639, y=464..479 only.
- **Overlays:**
  - status 2 → `COL_OVER` on non-head visible pixels;
  - status 3 with `COL_BG`=12'h8A4 → 12'h452;
  - blanking region → 0.
- **Blink:** with `VGA_MINE_BLINK_EN`, BLINK_FRAMES=2 → mine pixel visible in frames 0–1, background in frames 2–3, visible again in frame 4.
